// File: rtl/source_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// source_arb_pkg
// Shared definitions for the source arbiter: default parameter values, the
// arbiter FSM state type and a small index-wrap helper.
// -----------------------------------------------------------------------------
package source_arb_pkg;

  localparam int unsigned DEF_N_SRC  = 32'd4;
  localparam int unsigned DEF_DATA_W = 32'd8;
  localparam int unsigned DEF_BURST  = 32'd4;

  // Arbiter FSM states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  // Next index modulo n; n need not be a power of two
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage

// File: rtl/source_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first requesting index at or
// after i_ptr, wrapping modulo N_SRC.
// Ports:
//   i_req  [N_SRC-1:0]  request vector
//   i_ptr  [IW-1:0]     search start index
//   o_idx  [IW-1:0]     selected index (0 when nothing requests)
//   o_any               at least one request is set
// -----------------------------------------------------------------------------
module rr_pick
  import source_arb_pkg::*;
#(
  parameter int N_SRC = DEF_N_SRC,
  localparam int IW = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  logic [IW-1:0] w_pos;

  // Scan from the farthest offset down to offset 0 so the nearest request
  // to i_ptr is the last (winning) assignment.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    w_pos = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      w_pos = IW'((int'(i_ptr) + i) % N_SRC);
      o_idx = i_req[w_pos] ? w_pos : o_idx;
      o_any = o_any | i_req[w_pos];
    end
  end

endmodule

// File: rtl/source_arbiter.sv
// -----------------------------------------------------------------------------
// source_arbiter
// Round-robin N_SRC:1 stream arbiter with burst locking and a one-entry
// registered output stage.
// Ports:
//   clk_i, rstn_i (async, active-low)
//   valid_i/data_i/ready_o : per-source stream inputs (ready_o combinational)
//   valid_o/data_o/id_o    : registered sink stream, id_o = producing source
//   ready_i                : sink ready
//   cnt_o                  : per-source 16-bit accepted-beat counters
// Build option: define SOURCE_ARB_CNT_EN to build the beat counters;
// otherwise cnt_o is tied to zero.
// -----------------------------------------------------------------------------
module source_arbiter
  import source_arb_pkg::*;
#(
  parameter int N_SRC  = DEF_N_SRC,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BURST  = DEF_BURST,
  localparam int IW = $clog2(N_SRC)
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [N_SRC-1:0]        valid_i,
  input  logic [N_SRC*DATA_W-1:0] data_i,
  output logic [N_SRC-1:0]        ready_o,
  output logic                    valid_o,
  output logic [DATA_W-1:0]       data_o,
  output logic [IW-1:0]           id_o,
  input  logic                    ready_i,
  output logic [N_SRC*16-1:0]     cnt_o
);

  state_e              r_state;
  logic [IW-1:0]       r_gnt;
  logic [IW-1:0]       r_ptr;
  logic [7:0]          r_burst;
  logic                r_valid;
  logic [DATA_W-1:0]   r_data;
  logic [IW-1:0]       r_id;

  logic [IW-1:0]       w_pick_idx;
  logic                w_pick_any;
  logic                w_rdy_gnt;
  logic                w_src_xfer;
  logic                w_burst_done;
  logic [7:0]          w_burst_nxt;
  logic [IW-1:0]       w_gnt_inc;

  rr_pick #(.N_SRC(N_SRC)) u_pick (
    .i_req (valid_i),
    .i_ptr (r_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // The granted source may push whenever the output stage is empty or draining
  assign w_rdy_gnt    = (r_state == LOCK) & (~r_valid | ready_i);
  assign w_src_xfer   = w_rdy_gnt & valid_i[r_gnt];
  assign w_burst_nxt  = r_burst + 8'd1;
  assign w_burst_done = (w_burst_nxt == 8'(BURST));
  assign w_gnt_inc    = IW'(wrap_inc(32'(r_gnt), 32'(N_SRC)));

  // One-hot ready toward the granted source only
  always_comb begin
    ready_o        = '0;
    ready_o[r_gnt] = w_rdy_gnt;
  end

  // Arbitration FSM: grant, burst count and round-robin pointer
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_burst <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_gnt   <= w_pick_idx;
            r_burst <= 8'd0;
            r_state <= LOCK;
          end else begin
            r_state <= IDLE;
          end
        end
        LOCK: begin
          if (w_src_xfer) begin
            r_burst <= w_burst_nxt;
          end else begin
            r_burst <= r_burst;
          end
          // Release on source drop-out or when the last allowed beat is taken
          if (!valid_i[r_gnt] || (w_src_xfer && w_burst_done)) begin
            r_state <= IDLE;
            r_ptr   <= w_gnt_inc;
          end else begin
            r_state <= LOCK;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output register: reload on a source beat (even while draining), else drain
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
    end else if (w_src_xfer) begin
      r_valid <= 1'b1;
      r_data  <= data_i[r_gnt*DATA_W +: DATA_W];
      r_id    <= r_gnt;
    end else if (r_valid && ready_i) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign id_o    = r_id;

`ifdef SOURCE_ARB_CNT_EN
  logic [15:0] r_cnt [N_SRC];

  // Per-source accepted-beat counters, wrapping at 16 bits
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < N_SRC; k++) r_cnt[k] <= 16'd0;
    end else begin
      for (int k = 0; k < N_SRC; k++) begin
        if (w_src_xfer && (r_gnt == IW'(k))) begin
          r_cnt[k] <= r_cnt[k] + 16'd1;
        end else begin
          r_cnt[k] <= r_cnt[k];
        end
      end
    end
  end

  // Flatten counters onto the output bus
  always_comb begin
    cnt_o = '0;
    for (int k = 0; k < N_SRC; k++) cnt_o[k*16 +: 16] = r_cnt[k];
  end
`else
  assign cnt_o = '0;
`endif

endmodule

// File: tb/tb_source_arbiter.sv
// -----------------------------------------------------------------------------
// tb_source_arbiter
// Self-checking bench for source_arbiter. u_dut uses BURST=4, u_dut1 uses
// BURST=1 for the rotation check. Sink beats of u_dut are checked against a
// queue of source beats accepted by the handshake.
// -----------------------------------------------------------------------------
module tb_source_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    valid_a, ready_a, valid_b, ready_b;
  logic [N*DW-1:0] data_a, data_b;
  logic            vo_a, vo_b, rdy_a, rdy_b;
  logic [DW-1:0]   do_a, do_b;
  logic [IW-1:0]   id_a, id_b;
  logic [N*16-1:0] cnt_a, cnt_b;

  source_arbiter #(.N_SRC(4), .DATA_W(8), .BURST(4)) u_dut (
    .clk_i(clk), .rstn_i(rstn), .valid_i(valid_a), .data_i(data_a),
    .ready_o(ready_a), .valid_o(vo_a), .data_o(do_a), .id_o(id_a),
    .ready_i(rdy_a), .cnt_o(cnt_a));

  source_arbiter #(.N_SRC(4), .DATA_W(8), .BURST(1)) u_dut1 (
    .clk_i(clk), .rstn_i(rstn), .valid_i(valid_b), .data_i(data_b),
    .ready_o(ready_b), .valid_o(vo_b), .data_o(do_b), .id_o(id_b),
    .ready_i(rdy_b), .cnt_o(cnt_b));

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_rdy;
    logic [1:0] exp_id;
  } vec_t;

  beat_t      sb[$];
  beat_t      exp_beat;
  vec_t       tbl[6];
  logic [3:0] seq [N];
  logic [N-1:0] hs = '0;
  logic       mon_b = 1'b0;
  logic [1:0] exp_b = 2'd0;
  int         nb = 0;
  int         checks = 0;
  int         errors = 0;

  assign data_b = 32'hA5A5_A5A5;

  // Each source presents (index<<4) + its own beat sequence number
  always_comb begin
    data_a = '0;
    for (int s = 0; s < N; s++) data_a[s*DW +: DW] = 8'(s << 4) + {4'b0, seq[s]};
  end

  // Source sequence advances on each accepted beat
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < N; s++) seq[s] <= 4'd0;
    end else begin
      for (int s = 0; s < N; s++) if (hs[s]) seq[s] <= seq[s] + 4'd1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Advance one cycle; at the falling edge pop/compare sink beats and push accepted source beats
  task automatic step();
    @(negedge clk);
    if (rstn) begin
      if (vo_a && rdy_a) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_empty: got id %0d data %0h, required no beat", id_a, do_a);
        end else begin
          exp_beat = sb.pop_front();
          if (id_a !== exp_beat.id || do_a !== exp_beat.data) begin
            errors++;
            $display("FAIL sb_beat: got id %0d data %0h, required id %0d data %0h",
                     id_a, do_a, exp_beat.id, exp_beat.data);
          end
        end
      end
      for (int s = 0; s < N; s++)
        if (valid_a[s] && ready_a[s]) sb.push_back('{id: 2'(s), data: data_a[s*DW +: DW]});
      hs = valid_a & ready_a;
      if (mon_b && vo_b && rdy_b) begin
        chk("b_rotation", 64'(id_b), 64'(exp_b));
        exp_b = exp_b + 2'd1;
        nb++;
      end
    end else begin
      hs = '0;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    sb.delete();
    valid_a = '0; rdy_a = 1'b0;
    valid_b = '0; rdy_b = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  initial begin
    int beats;
    tbl[0] = '{4'b0001, 4'b0001, 2'd0};
    tbl[1] = '{4'b0110, 4'b0010, 2'd1};
    tbl[2] = '{4'b1000, 4'b1000, 2'd3};
    tbl[3] = '{4'b1100, 4'b0100, 2'd2};
    tbl[4] = '{4'b1010, 4'b0010, 2'd1};
    tbl[5] = '{4'b1111, 4'b0001, 2'd0};

    // Reset values
    do_reset();
    chk("rst_valid_o", 64'(vo_a), 64'd0);
    chk("rst_data_o", 64'(do_a), 64'd0);
    chk("rst_id_o", 64'(id_a), 64'd0);
    chk("rst_ready_o", 64'(ready_a), 64'd0);
    chk("rst_cnt_o", cnt_a, 64'd0);

    // First grant from reset: lowest requester, ready after 1 cycle, valid_o after 2
    for (int i = 0; i < 6; i++) begin
      do_reset();
      valid_a = tbl[i].valid;
      rdy_a   = 1'b1;
      #1;
      chk("tbl_idle_rdy", 64'(ready_a), 64'd0);
      step();
      chk("tbl_lock_rdy", 64'(ready_a), 64'(tbl[i].exp_rdy));
      chk("tbl_vo_early", 64'(vo_a), 64'd0);
      step();
      chk("tbl_vo", 64'(vo_a), 64'd1);
      chk("tbl_id", 64'(id_a), 64'(tbl[i].exp_id));
      valid_a = '0;
      step();
      step();
    end

    // Source 2 streaming: groups of 4 beats separated by one empty cycle
    do_reset();
    valid_a = 4'b0100;
    rdy_a   = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("burst_vo", 64'(vo_a), 64'((k >= 2) && (((k - 1) % 5) != 0)));
      if (vo_a) chk("burst_id", 64'(id_a), 64'd2);
    end
    valid_a = '0;
    step();
    step();
`ifndef SOURCE_ARB_CNT_EN
    chk("cnt_off", cnt_a, 64'd0);
`endif

    // Back-pressure: 0x10 from source 1 held while ready_i=0
    do_reset();
    valid_a = 4'b0010;
    rdy_a   = 1'b0;
    step();
    chk("bp_rdy_lock", 64'(ready_a), 64'b0010);
    step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_vo", 64'(vo_a), 64'd1);
      chk("bp_data", 64'(do_a), 64'h10);
      chk("bp_id", 64'(id_a), 64'd1);
      chk("bp_rdy", 64'(ready_a), 64'd0);
      step();
    end
    valid_a = '0;
    rdy_a   = 1'b1;
    step();
    step();

    // Source 3 drops after 2 beats: back to IDLE, next grant searched from 0
    do_reset();
    valid_a = 4'b1000;
    rdy_a   = 1'b1;
    step();
    step();
    step();
    valid_a = 4'b0110;
    step();
    chk("drop_idle_rdy", 64'(ready_a), 64'd0);
    step();
    chk("drop_regrant", 64'(ready_a), 64'b0010);
    valid_a = '0;
    step();
    step();

    // Reset asserted in LOCK with a full output register
    do_reset();
    valid_a = 4'b0001;
    rdy_a   = 1'b0;
    step();
    step();
    chk("rst_mid_pre", 64'(vo_a), 64'd1);
    rstn = 1'b0;
    #1;
    chk("rst_mid_vo", 64'(vo_a), 64'd0);
    chk("rst_mid_rdy", 64'(ready_a), 64'd0);
    chk("rst_mid_cnt", cnt_a, 64'd0);
    sb.delete();
    valid_a = '0;
    step();
    rstn  = 1'b1;
    valid_a = 4'b0100;
    rdy_a = 1'b1;
    #1;
    chk("rst_mid_idle", 64'(ready_a), 64'd0);
    step();
    chk("rst_mid_regrant", 64'(ready_a), 64'b0100);
    valid_a = '0;
    step();
    step();

    // BURST=1 rotation with all sources requesting
    do_reset();
    valid_b = 4'hF;
    rdy_b   = 1'b1;
    exp_b   = 2'd0;
    nb      = 0;
    mon_b   = 1'b1;
    for (int k = 0; k < 24; k++) step();
    mon_b   = 1'b0;
    valid_b = '0;
    chk("b_beat_count", 64'(nb), 64'd11);

`ifdef SOURCE_ARB_CNT_EN
    // 70000 beats from source 0: counter wraps to 4464
    do_reset();
    valid_a = 4'b0001;
    rdy_a   = 1'b1;
    beats   = 0;
    for (int k = 0; k < 95000 && beats < 70000; k++) begin
      step();
      if (hs[0]) beats++;
    end
    valid_a = '0;
    chk("cnt_beats", 64'(beats), 64'd70000);
    chk("cnt_wrap", 64'(cnt_a[15:0]), 64'd4464);
    step();
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
